// File: rtl/tcam_lookup_ctrl.sv
// Request front-end for tcam_top: registers commands onto the flattened tcam_top_req bus,
// tracks in-flight searches with a token pipeline and queues results in a credit-protected FIFO.
// tcam_top_req = {search, key_we, we, addr, key, mask, data}; tcam_top_resp = {data_vld, addr, data}.

`ifndef KEY_WIDTH
`define KEY_WIDTH 16
`endif
`ifndef VALUE_WIDTH
`define VALUE_WIDTH 32
`endif
`ifndef CAM_ADDR_WIDTH
`define CAM_ADDR_WIDTH 6
`endif

module tcam_lookup_ctrl #(
    parameter int KEY_WIDTH      = `KEY_WIDTH,
    parameter int VALUE_WIDTH    = `VALUE_WIDTH,
    parameter int ADDR_WIDTH     = `CAM_ADDR_WIDTH,
    parameter int LOOKUP_LATENCY = 1,
    parameter int RESP_DEPTH     = 4,
    parameter int TAG_WIDTH      = 4,
    localparam int REQ_WIDTH     = 3 + ADDR_WIDTH + 2 * KEY_WIDTH + VALUE_WIDTH,
    localparam int RESP_WIDTH    = 1 + ADDR_WIDTH + VALUE_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [KEY_WIDTH-1:0]   req_key,
    input  logic [KEY_WIDTH-1:0]   req_mask,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [VALUE_WIDTH-1:0] req_data,
    input  logic [TAG_WIDTH-1:0]   req_tag,
    output logic [REQ_WIDTH-1:0]   tcam_top_req,
    input  logic [RESP_WIDTH-1:0]  tcam_top_resp,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic                   resp_hit,
    output logic [ADDR_WIDTH-1:0]  resp_addr,
    output logic [VALUE_WIDTH-1:0] resp_data,
    output logic [TAG_WIDTH-1:0]   resp_tag
);

    localparam logic [1:0] OP_SEARCH   = 2'd0;
    localparam logic [1:0] OP_WR_KEY   = 2'd1;
    localparam logic [1:0] OP_WR_VALUE = 2'd2;

    localparam logic [0:0] STATE_RUN   = 1'b0;
    localparam logic [0:0] STATE_DRAIN = 1'b1;

    localparam int PTR_W   = $clog2(RESP_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int SUM_W   = $clog2(RESP_DEPTH + LOOKUP_LATENCY + 2) + 1;
    localparam int ENTRY_W = 1 + ADDR_WIDTH + VALUE_WIDTH + TAG_WIDTH;

    logic [0:0]             state_reg, state_next;
    logic [REQ_WIDTH-1:0]   issue_reg, issue_next;
    logic                   issue_search_reg;
    logic [TAG_WIDTH-1:0]   issue_tag_reg;
    logic                   tok_vld_reg [LOOKUP_LATENCY];
    logic [TAG_WIDTH-1:0]   tok_tag_reg [LOOKUP_LATENCY];
    logic                   tok_vld_in  [LOOKUP_LATENCY];
    logic [TAG_WIDTH-1:0]   tok_tag_in  [LOOKUP_LATENCY];
    logic [ENTRY_W-1:0]     fifo_mem [RESP_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]       count_reg;
    logic [SUM_W-1:0]       inflight;
    logic                   credit_ok, accept, push, pop, lookup_hit;
    logic [ENTRY_W-1:0]     push_entry, head_entry;

    // The issue register counts as the first token stage for credit purposes.
    always_comb begin
        inflight = SUM_W'(issue_search_reg);
        for (int i = 0; i < LOOKUP_LATENCY; i++) begin
            inflight = inflight + SUM_W'(tok_vld_reg[i]);
        end
    end

    assign credit_ok = (SUM_W'(count_reg) + inflight) < SUM_W'(RESP_DEPTH);

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        if (!rst) begin
            if (state_reg == STATE_RUN) begin
                case (req_op)
                    OP_SEARCH: req_ready = credit_ok;
                    OP_WR_VALUE: begin
                        req_ready = (inflight == '0);
                        if (req_valid && inflight != '0) begin
                            state_next = STATE_DRAIN;
                        end
                    end
                    default: req_ready = 1'b1;
                endcase
            end else if (inflight == '0) begin
                state_next = STATE_RUN;
            end
        end
    end

    assign accept = req_valid && req_ready;

    always_comb begin
        issue_next = '0;
        if (accept) begin
            case (req_op)
                OP_SEARCH:   issue_next = {3'b100, {ADDR_WIDTH{1'b0}}, req_key,
                                           {KEY_WIDTH{1'b0}}, {VALUE_WIDTH{1'b0}}};
                OP_WR_KEY:   issue_next = {3'b010, req_addr, req_key, req_mask,
                                           {VALUE_WIDTH{1'b0}}};
                OP_WR_VALUE: issue_next = {3'b001, req_addr, {KEY_WIDTH{1'b0}},
                                           {KEY_WIDTH{1'b0}}, req_data};
                default:     issue_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= STATE_RUN;
            issue_reg        <= '0;
            issue_search_reg <= 1'b0;
            issue_tag_reg    <= '0;
        end else begin
            state_reg        <= state_next;
            issue_reg        <= issue_next;
            issue_search_reg <= accept && (req_op == OP_SEARCH);
            issue_tag_reg    <= (accept && req_op == OP_SEARCH) ? req_tag : '0;
        end
    end

    assign tcam_top_req = issue_reg;

    genvar gi;
    generate
        for (gi = 0; gi < LOOKUP_LATENCY; gi++) begin : g_tok
            if (gi == 0) begin : g_first
                assign tok_vld_in[gi] = issue_search_reg;
                assign tok_tag_in[gi] = issue_tag_reg;
            end else begin : g_next
                assign tok_vld_in[gi] = tok_vld_reg[gi-1];
                assign tok_tag_in[gi] = tok_tag_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < LOOKUP_LATENCY; i++) begin
            if (rst) begin
                tok_vld_reg[i] <= 1'b0;
                tok_tag_reg[i] <= '0;
            end else begin
                tok_vld_reg[i] <= tok_vld_in[i];
                tok_tag_reg[i] <= tok_tag_in[i];
            end
        end
    end

    // A token leaving the pipeline lines up with its tcam_top_resp; misses are zeroed.
    assign push       = tok_vld_reg[LOOKUP_LATENCY-1];
    assign lookup_hit = tcam_top_resp[RESP_WIDTH-1];
    assign push_entry = {lookup_hit,
                         lookup_hit ? tcam_top_resp[VALUE_WIDTH +: ADDR_WIDTH] : {ADDR_WIDTH{1'b0}},
                         lookup_hit ? tcam_top_resp[VALUE_WIDTH-1:0] : {VALUE_WIDTH{1'b0}},
                         tok_tag_reg[LOOKUP_LATENCY-1]};

    assign resp_valid = (count_reg != '0);
    assign pop        = resp_valid && resp_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_entry = fifo_mem[rd_ptr_reg];
    assign {resp_hit, resp_addr, resp_data, resp_tag} = resp_valid ? head_entry : '0;

endmodule

// File: tb/tb_tcam_lookup_ctrl.sv
// Self-checking bench for tcam_lookup_ctrl: a behavioural tcam_top stub drives the response
// bus, and a spec-level model (shadow TCAM, result queue, credit counts) predicts every output.

module tb_tcam_lookup_ctrl;

    localparam int KW = 8, VW = 8, AW = 4, L = 1, D = 4, TW = 4;
    localparam int NENT   = 1 << AW;
    localparam int REQ_W  = 3 + AW + 2 * KW + VW;
    localparam int RESP_W = 1 + AW + VW;

    typedef struct packed {
        logic          hit;
        logic [AW-1:0] addr;
        logic [VW-1:0] data;
        logic [TW-1:0] tag;
    } resp_t;

    logic              clk = 1'b0, rst = 1'b1;
    logic              req_valid = 1'b0, req_ready;
    logic [1:0]        req_op = '0;
    logic [KW-1:0]     req_key = '0, req_mask = '0;
    logic [AW-1:0]     req_addr = '0;
    logic [VW-1:0]     req_data = '0;
    logic [TW-1:0]     req_tag = '0;
    logic [REQ_W-1:0]  tcam_top_req;
    logic [RESP_W-1:0] tcam_top_resp = '0;
    logic              resp_valid, resp_ready = 1'b0, resp_hit;
    logic [AW-1:0]     resp_addr;
    logic [VW-1:0]     resp_data;
    logic [TW-1:0]     resp_tag;

    tcam_lookup_ctrl #(
        .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .ADDR_WIDTH(AW),
        .LOOKUP_LATENCY(L), .RESP_DEPTH(D), .TAG_WIDTH(TW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_key(req_key), .req_mask(req_mask), .req_addr(req_addr),
        .req_data(req_data), .req_tag(req_tag),
        .tcam_top_req(tcam_top_req), .tcam_top_resp(tcam_top_resp),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
        .resp_addr(resp_addr), .resp_data(resp_data), .resp_tag(resp_tag)
    );

    always #5 clk = ~clk;

    // tcam_top stand-in: one-cycle lookup, mask bit 1 = don't care, lowest index wins.
    logic [KW-1:0] s_key  [NENT] = '{default: '0};
    logic [KW-1:0] s_mask [NENT] = '{default: '0};
    logic          s_kv   [NENT] = '{default: 1'b0};
    logic [VW-1:0] s_val  [NENT] = '{default: '0};

    always @(posedge clk) begin : stub
        logic          hit;
        logic [AW-1:0] idx, a;
        logic [KW-1:0] k;
        hit = 1'b0;
        idx = AW'($urandom_range(0, NENT - 1));
        k   = tcam_top_req[VW+KW +: KW];
        a   = tcam_top_req[VW+2*KW +: AW];
        if (tcam_top_req[REQ_W-1]) begin
            for (int i = NENT - 1; i >= 0; i--) begin
                if (s_kv[i] && (((k ^ s_key[i]) & ~s_mask[i]) == '0)) begin
                    hit = 1'b1;
                    idx = AW'(i);
                end
            end
        end
        tcam_top_resp <= {hit, idx, hit ? s_val[idx] : VW'($urandom)};
        if (tcam_top_req[REQ_W-2]) begin
            s_key[a]  <= k;
            s_mask[a] <= tcam_top_req[VW +: KW];
            s_kv[a]   <= 1'b1;
        end
        if (tcam_top_req[REQ_W-3]) begin
            s_val[a] <= tcam_top_req[VW-1:0];
        end
    end

    // Reference model state
    logic [KW-1:0]    m_key  [NENT] = '{default: '0};
    logic [KW-1:0]    m_mask [NENT] = '{default: '0};
    logic             m_kv   [NENT] = '{default: 1'b0};
    logic [VW-1:0]    m_val  [NENT] = '{default: '0};
    resp_t            exp_q[$];
    int               acc_cycles[$];
    int               outstanding = 0, wv_age = 0, cyc = 0, last_pop_cyc = -1;
    logic [REQ_W-1:0] exp_issue = '0;
    int               vectors = 0, miscompares = 0;

    function automatic resp_t model_lookup(input logic [KW-1:0] k, input logic [TW-1:0] t);
        resp_t r;
        r     = '0;
        r.tag = t;
        for (int i = 0; i < NENT; i++) begin
            if (!r.hit && m_kv[i] && ((k & ~m_mask[i]) == (m_key[i] & ~m_mask[i]))) begin
                r.hit  = 1'b1;
                r.addr = AW'(i);
                r.data = m_val[i];
            end
        end
        return r;
    endfunction

    // Searches still owed to the FIFO in cycle c: those accepted in cycles c-1-L .. c-1.
    function automatic int pipe_at(input int c);
        int n = 0;
        foreach (acc_cycles[i]) begin
            if (acc_cycles[i] >= c - 1 - L && acc_cycles[i] <= c - 1) n++;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, check just after, advance to the next falling edge.
    task automatic cycle(input logic v, input logic [1:0] op, input logic [KW-1:0] k,
                         input logic [KW-1:0] m, input logic [AW-1:0] a, input logic [VW-1:0] d,
                         input logic [TW-1:0] t, input logic rr, output logic acc);
        resp_t e;
        logic  pop;
        req_valid = v; req_op = op; req_key = k; req_mask = m;
        req_addr = a; req_data = d; req_tag = t; resp_ready = rr;
        #1;
        chk("issue_bus", tcam_top_req, exp_issue);
        if (tcam_top_req[REQ_W-3]) chk("we_vs_tokens", pipe_at(cyc), 0);
        if (v && op == 2'd0) chk("ready_search", req_ready, outstanding < D);
        if (v && (op == 2'd1 || op == 2'd3)) chk("ready_nonsearch", req_ready, 1'b1);
        if (v && op == 2'd2)
            chk("ready_wrval", req_ready,
                (pipe_at(cyc) == 0) && (wv_age == 0 || pipe_at(cyc - 1) == 0));
        pop = resp_valid && rr;
        if (pop) begin
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", resp_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("resp_hit", resp_hit, e.hit);
                chk("resp_addr", resp_addr, e.addr);
                chk("resp_data", resp_data, e.data);
                chk("resp_tag", resp_tag, e.tag);
                outstanding--;
                last_pop_cyc = cyc;
            end
        end
        acc = v && req_ready;
        exp_issue = '0;
        if (acc) begin
            case (op)
                2'd0: begin
                    exp_q.push_back(model_lookup(k, t));
                    acc_cycles.push_back(cyc);
                    outstanding++;
                    exp_issue = {3'b100, AW'(0), k, KW'(0), VW'(0)};
                end
                2'd1: begin
                    m_key[a] = k; m_mask[a] = m; m_kv[a] = 1'b1;
                    exp_issue = {3'b010, a, k, m, VW'(0)};
                end
                2'd2: begin
                    m_val[a] = d;
                    exp_issue = {3'b001, a, KW'(0), KW'(0), d};
                end
                default: exp_issue = '0;
            endcase
        end
        if (v && op == 2'd2) wv_age = acc ? 0 : wv_age + 1;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] op, input logic [KW-1:0] k, input logic [KW-1:0] m,
                        input logic [AW-1:0] a, input logic [VW-1:0] d, input logic [TW-1:0] t,
                        input logic rr, output int acc_cyc);
        logic acc = 1'b0;
        acc_cyc = -1;
        for (int i = 0; i < 40 && !acc; i++) begin
            acc_cyc = cyc;
            cycle(1'b1, op, k, m, a, d, t, rr, acc);
        end
        if (!acc) chk("send_timeout", acc, 1'b1);
    endtask

    task automatic idle(input int n, input logic rr);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, '0, '0, '0, '0, '0, rr, acc);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; req_valid = 1'b1; req_op = 2'd0; resp_ready = 1'b1;
        #1;
        chk("rst_ready", req_ready, 1'b0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            #1;
            chk("rst_ready", req_ready, 1'b0);
            chk("rst_resp_valid", resp_valid, 1'b0);
            chk("rst_resp_fields", {resp_hit, resp_addr, resp_data, resp_tag}, '0);
            chk("rst_issue_bus", tcam_top_req, '0);
        end
        rst = 1'b0; req_valid = 1'b0;
        exp_q.delete(); acc_cycles.delete();
        outstanding = 0; wv_age = 0; exp_issue = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end, required finish before 200000");
        $fatal(1);
    end

    initial begin
        int   a1, a2, wa, sa, n, bp_acc;
        logic acc, have;
        logic [1:0]    r_op;
        logic [KW-1:0] r_key, r_mask;
        logic [AW-1:0] r_addr;
        logic [VW-1:0] r_data;
        logic [TW-1:0] r_tag;

        @(negedge clk);
        do_reset(3);

        // Program entry 5 = key 0x5A exact, value 0xAB; then single search with latency check.
        send(2'd1, 8'h5A, 8'h00, 4'd5, 8'h00, 4'd0, 1'b1, a1);
        send(2'd2, 8'h00, 8'h00, 4'd5, 8'hAB, 4'd0, 1'b1, a1);
        idle(3, 1'b1);
        last_pop_cyc = -1;
        send(2'd0, 8'h5A, 8'h00, 4'd0, 8'h00, 4'd3, 1'b1, sa);
        idle(6, 1'b1);
        chk("first_resp_latency", last_pop_cyc, sa + L + 2);

        // Miss
        send(2'd0, 8'h00, 8'h00, 4'd0, 8'h00, 4'd7, 1'b1, sa);
        idle(6, 1'b1);

        // Backpressure: six searches offered with the consumer stalled.
        bp_acc = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(bp_acc < 6, 2'd0, (bp_acc % 2 == 1) ? 8'h5A : KW'(bp_acc), '0, '0, '0,
                  TW'(bp_acc + 8), 1'b0, acc);
            if (acc) bp_acc++;
        end
        chk("bp_accepted", bp_acc, 4);
        cycle(1'b1, 2'd0, 8'h5A, '0, '0, '0, TW'(bp_acc + 8), 1'b1, acc);
        if (acc) bp_acc++;
        for (int i = 0; i < 6; i++) begin
            cycle(bp_acc < 6, 2'd0, 8'h5A, '0, '0, '0, TW'(bp_acc + 8), 1'b0, acc);
            if (acc) bp_acc++;
        end
        chk("bp_after_pop", bp_acc, 5);
        idle(12, 1'b1);

        // Value write right behind two searches must drain first.
        send(2'd0, 8'h5A, 8'h00, 4'd0, 8'h00, 4'd1, 1'b1, a1);
        send(2'd0, 8'h11, 8'h00, 4'd0, 8'h00, 4'd2, 1'b1, a2);
        send(2'd2, 8'h00, 8'h00, 4'd5, 8'hCD, 4'd0, 1'b1, wa);
        chk("wrval_accept_cycle", wa, a2 + L + 3);
        send(2'd0, 8'h5A, 8'h00, 4'd0, 8'h00, 4'd9, 1'b1, sa);
        idle(6, 1'b1);

        // Back-to-back searches with a free-running consumer.
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 2'd0, KW'(i) ^ 8'h5A, '0, '0, '0, TW'(i), 1'b1, acc);
            if (acc) n++;
        end
        chk("throughput", n, 20);
        idle(6, 1'b1);

        // Random mix of all ops against random consumer backpressure.
        have = 1'b0;
        r_op = '0; r_key = '0; r_mask = '0; r_addr = '0; r_data = '0; r_tag = '0;
        for (int i = 0; i < 400; i++) begin
            if (!have && $urandom_range(0, 9) < 8) begin
                have = 1'b1;
                case ($urandom_range(0, 9))
                    6:       r_op = 2'd1;
                    7:       r_op = 2'd2;
                    8:       r_op = 2'd3;
                    default: r_op = 2'd0;
                endcase
                r_key  = KW'($urandom_range(0, 15));
                r_mask = KW'($urandom_range(0, 3));
                r_addr = AW'($urandom_range(0, NENT - 1));
                r_data = VW'($urandom);
                r_tag  = TW'($urandom);
            end
            cycle(have, r_op, r_key, r_mask, r_addr, r_data, r_tag,
                  $urandom_range(0, 3) != 0, acc);
            if (acc) have = 1'b0;
        end
        idle(10, 1'b1);
        chk("random_drained", exp_q.size(), 0);

        // Reset with searches in flight and results queued.
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'd0, 8'h5A, '0, '0, '0, TW'(i), 1'b0, acc);
        do_reset(1);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("post_rst_valid", resp_valid, 1'b0);
            cycle(1'b0, 2'd0, '0, '0, '0, '0, '0, 1'b1, acc);
        end
        chk("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
